// File: rtl/dmem_pkg.sv
// Shared types and encodings for the data-memory load/store controller.
// - state_e  : controller FSM states
// - SZ_*     : req_size encodings (11 is illegal)
// - BWE_*    : common byte-write-enable patterns
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [3:0] BWE_NONE = 4'b0000;
  localparam logic [3:0] BWE_LO   = 4'b0011;
  localparam logic [3:0] BWE_HI   = 4'b1100;
  localparam logic [3:0] BWE_ALL  = 4'b1111;

endpackage

// File: rtl/dmem_lsu_ctrl_if.sv
// Bundle of the CPU request/response handshake and the SRAM bus seen by dmem_lsu_ctrl.
// - master : CPU datapath plus SRAM macro (drives req_*, sram_rdata)
// - slave  : the controller (drives req_ready, rsp_*, busy, sram_* except sram_rdata)
interface dmem_lsu_ctrl_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned SRAM_AW = 10
);

  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [1:0]         req_size;
  logic               req_unsigned;
  logic [ADDR_W-1:0]  req_addr;
  logic [31:0]        req_wdata;

  logic               rsp_valid;
  logic [31:0]        rsp_rdata;
  logic               rsp_err;
  logic               busy;

  logic               sram_cs;
  logic               sram_we;
  logic [3:0]         sram_bwe;
  logic [SRAM_AW-1:0] sram_addr;
  logic [31:0]        sram_wdata;
  logic [31:0]        sram_rdata;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, sram_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
    input  sram_cs, sram_we, sram_bwe, sram_addr, sram_wdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, sram_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
    output sram_cs, sram_we, sram_bwe, sram_addr, sram_wdata
  );

endinterface

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatting shared by the store and load paths (purely combinational).
// - size_i, addr_lo_i : access size and byte offset within the word
// - unsigned_i        : zero-extend sub-word loads instead of sign-extending
// - wdata_i / wdata_o : right-aligned store data / lane-replicated SRAM write data
// - bwe_o             : per-byte write enables for the store
// - rdata_i / rdata_o : raw SRAM word / selected and extended load result
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  bwe_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    bwe_o   = BWE_NONE;
    wdata_o = 32'h0;
    rdata_o = 32'h0;

    unique case (size_i)
      SZ_B: begin
        bwe_o   = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = unsigned_i ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      SZ_H: begin
        bwe_o   = addr_lo_i[1] ? BWE_HI : BWE_LO;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = unsigned_i ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      SZ_W: begin
        bwe_o   = BWE_ALL;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
      end
      default: begin
        bwe_o   = BWE_NONE;
        wdata_o = 32'h0;
        rdata_o = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// Load/store controller between the CPU datapath and a synchronous single-port data SRAM.
// Accepts one request at a time over a valid/ready handshake, drives a single SRAM cycle,
// waits WAIT_STATES cycles for read data and returns a one-cycle response pulse.
// - clk  : rising-edge clock
// - rst  : synchronous active-high reset
// - bus  : request/response handshake and SRAM bus (slave view)
module dmem_lsu_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic          clk,
  input  logic          rst,
  dmem_lsu_ctrl_if.slave bus
);

  localparam int unsigned SRAM_AW  = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WaitInit = 4'(WAIT_STATES);

  if (WAIT_STATES < 1 || WAIT_STATES > 15) begin : gen_bad_wait_states
    $error("dmem_lsu_ctrl: WAIT_STATES must be in 1..15");
  end
  if (ADDR_W < SRAM_AW + 2) begin : gen_bad_addr_w
    $error("dmem_lsu_ctrl: ADDR_W too narrow for DEPTH_WORDS");
  end

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [31:0]        rdata_q, rdata_d;

  logic               we_q;
  logic [1:0]         size_q;
  logic               uns_q;
  logic [SRAM_AW+1:0] addr_q;
  logic [31:0]        wdata_q;
  logic               err_q;

  logic               accept;
  logic               req_err;
  logic [ADDR_W-1:0]  word_idx;

  logic [3:0]         fmt_bwe;
  logic [31:0]        fmt_wdata;
  logic [31:0]        fmt_rdata;

  assign bus.req_ready = (state_q == IDLE) && !rst;
  assign bus.busy      = (state_q != IDLE);
  assign bus.rsp_rdata = rdata_q;
  assign accept        = bus.req_valid && bus.req_ready;
  assign word_idx      = bus.req_addr >> 2;

  // Decided on the live request so an error can skip the SRAM entirely.
  always_comb begin
    req_err = 1'b0;
    unique case (bus.req_size)
      SZ_B:    req_err = 1'b0;
      SZ_H:    req_err = bus.req_addr[0];
      SZ_W:    req_err = |bus.req_addr[1:0];
      default: req_err = 1'b1;
    endcase
    if (word_idx >= ADDR_W'(DEPTH_WORDS)) begin
      req_err = 1'b1;
    end
  end

  dmem_lane_fmt u_lane_fmt (
    .size_i     (size_q),
    .addr_lo_i  (addr_q[1:0]),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .rdata_i    (bus.sram_rdata),
    .bwe_o      (fmt_bwe),
    .wdata_o    (fmt_wdata),
    .rdata_o    (fmt_rdata)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rdata_d        = rdata_q;
    bus.sram_cs    = 1'b0;
    bus.sram_we    = 1'b0;
    bus.sram_bwe   = BWE_NONE;
    bus.sram_addr  = '0;
    bus.sram_wdata = 32'h0;
    bus.rsp_valid  = 1'b0;
    bus.rsp_err    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_err) begin
            state_d = RESP;
            rdata_d = 32'h0;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        bus.sram_cs    = 1'b1;
        bus.sram_we    = we_q;
        bus.sram_addr  = addr_q[SRAM_AW+1:2];
        bus.sram_bwe   = we_q ? fmt_bwe : BWE_NONE;
        bus.sram_wdata = we_q ? fmt_wdata : 32'h0;
        cnt_d          = WaitInit;
        state_d        = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // Last wait cycle: SRAM read data is valid now.
        if (cnt_q == 4'd1) begin
          rdata_d = we_q ? 32'h0 : fmt_rdata;
          cnt_d   = 4'd0;
          state_d = RESP;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = err_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      we_q    <= 1'b0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      if (accept) begin
        we_q    <= bus.req_we;
        size_q  <= bus.req_size;
        uns_q   <= bus.req_unsigned;
        addr_q  <= bus.req_addr[SRAM_AW+1:0];
        wdata_q <= bus.req_wdata;
        err_q   <= req_err;
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Directed bench for dmem_lsu_ctrl: one instance with WAIT_STATES=1 and one with
// WAIT_STATES=4, each backed by a small SRAM model with matching read latency.
module tb_dmem_lsu_ctrl;
  import dmem_pkg::*;

  typedef struct {
    int          rsp_cyc;
    int          cs_cyc;
    int          cs_cnt;
    int          busy_cnt;
    int          ready_cyc;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  bwe;
    logic [31:0] wdata;
    logic [9:0]  saddr;
    logic        swe;
  } res_t;

  logic clk;
  logic rst1, rst4;
  logic sel;

  logic        req_valid, req_we, req_uns;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  logic        o_ready, o_busy, o_rsp_valid, o_err, o_cs, o_swe;
  logic [31:0] o_rdata, o_swdata;
  logic [3:0]  o_bwe;
  logic [9:0]  o_saddr;

  int n_checks = 0;
  int n_fail   = 0;
  int excl_viol = 0;

  dmem_lsu_ctrl_if #(.ADDR_W(32), .SRAM_AW(10)) if1 ();
  dmem_lsu_ctrl_if #(.ADDR_W(32), .SRAM_AW(10)) if4 ();

  dmem_lsu_ctrl #(.ADDR_W(32), .DEPTH_WORDS(1024), .WAIT_STATES(1)) u_dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (if1)
  );

  dmem_lsu_ctrl #(.ADDR_W(32), .DEPTH_WORDS(1024), .WAIT_STATES(4)) u_dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (if4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign if1.req_valid    = req_valid & ~sel;
  assign if4.req_valid    = req_valid & sel;
  assign if1.req_we       = req_we;
  assign if4.req_we       = req_we;
  assign if1.req_size     = req_size;
  assign if4.req_size     = req_size;
  assign if1.req_unsigned = req_uns;
  assign if4.req_unsigned = req_uns;
  assign if1.req_addr     = req_addr;
  assign if4.req_addr     = req_addr;
  assign if1.req_wdata    = req_wdata;
  assign if4.req_wdata    = req_wdata;

  assign o_ready     = sel ? if4.req_ready  : if1.req_ready;
  assign o_busy      = sel ? if4.busy       : if1.busy;
  assign o_rsp_valid = sel ? if4.rsp_valid  : if1.rsp_valid;
  assign o_err       = sel ? if4.rsp_err    : if1.rsp_err;
  assign o_rdata     = sel ? if4.rsp_rdata  : if1.rsp_rdata;
  assign o_cs        = sel ? if4.sram_cs    : if1.sram_cs;
  assign o_swe       = sel ? if4.sram_we    : if1.sram_we;
  assign o_bwe       = sel ? if4.sram_bwe   : if1.sram_bwe;
  assign o_swdata    = sel ? if4.sram_wdata : if1.sram_wdata;
  assign o_saddr     = sel ? if4.sram_addr  : if1.sram_addr;

  // SRAM models: read data valid exactly WAIT_STATES cycles after the cs cycle.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[8*b +: 8] = be[b] ? nw[8*b +: 8] : old[8*b +: 8];
    return res;
  endfunction

  logic [31:0] mem1 [0:1023];
  logic [31:0] mem4 [0:1023];
  logic [31:0] rd1_q;
  logic [31:0] p4 [0:3];

  always @(posedge clk) begin
    rd1_q <= 32'h0;
    if (if1.sram_cs) begin
      if (if1.sram_we) mem1[if1.sram_addr] <= merge(mem1[if1.sram_addr], if1.sram_wdata,
                                                    if1.sram_bwe);
      else rd1_q <= mem1[if1.sram_addr];
    end
  end
  assign if1.sram_rdata = rd1_q;

  always @(posedge clk) begin
    p4[0] <= (if4.sram_cs && !if4.sram_we) ? mem4[if4.sram_addr] : 32'h0;
    p4[1] <= p4[0];
    p4[2] <= p4[1];
    p4[3] <= p4[2];
    if (if4.sram_cs && if4.sram_we)
      mem4[if4.sram_addr] <= merge(mem4[if4.sram_addr], if4.sram_wdata, if4.sram_bwe);
  end
  assign if4.sram_rdata = p4[3];

  always @(negedge clk) begin
    if ((if1.rsp_valid && if1.req_ready) || (if4.rsp_valid && if4.req_ready))
      excl_viol <= excl_viol + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge while the selected DUT is idle. Cycle 0 is the accept edge;
  // returns at the negedge of the first cycle where req_ready is back.
  task automatic run_req(input string tag, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input bit hold, output res_t r);
    r.rsp_cyc = -1; r.cs_cyc = -1; r.cs_cnt = 0; r.busy_cnt = 0; r.ready_cyc = -1;
    r.rdata = 32'hDEADBEEF; r.err = 1'bx; r.bwe = 4'h0; r.wdata = 32'h0;
    r.saddr = 10'h0; r.swe = 1'b0;
    req_we = we; req_size = size; req_uns = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    #1;
    check({tag, "_ready"}, 32'(o_ready), 32'd1);
    @(posedge clk);
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (!hold) req_valid = 1'b0;
      if (o_cs) begin
        if (r.cs_cyc < 0) begin
          r.cs_cyc = cyc; r.bwe = o_bwe; r.wdata = o_swdata; r.saddr = o_saddr; r.swe = o_swe;
        end
        r.cs_cnt++;
      end
      if (o_busy) r.busy_cnt++;
      if (o_rsp_valid && r.rsp_cyc < 0) begin
        r.rsp_cyc = cyc; r.rdata = o_rdata; r.err = o_err;
      end
      if (o_ready) begin
        r.ready_cyc = cyc;
        break;
      end
    end
  endtask

  res_t r;
  int   wait_n;
  int   pulses;

  initial begin
    sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = SZ_W; req_uns = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    rst1 = 1'b1; rst4 = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("rst_cs", 32'(o_cs), 32'd0);
    check("rst_rdata", o_rdata, 32'h0);
    rst1 = 1'b0; rst4 = 1'b0;
    #1;
    check("rst_ready_release", 32'(o_ready), 32'd1);
    @(negedge clk);

    // 1: sw / lw word
    run_req("sw8", 1'b1, SZ_W, 1'b0, 32'h8, 32'h12345678, 1'b0, r);
    check("sw8_cs_cyc", 32'(r.cs_cyc), 32'd1);
    check("sw8_cs_cnt", 32'(r.cs_cnt), 32'd1);
    check("sw8_bwe", 32'(r.bwe), 32'hF);
    check("sw8_saddr", 32'(r.saddr), 32'd2);
    check("sw8_swe", 32'(r.swe), 32'd1);
    check("sw8_wdata", r.wdata, 32'h12345678);
    check("sw8_rsp_cyc", 32'(r.rsp_cyc), 32'd3);
    check("sw8_err", 32'(r.err), 32'd0);
    check("sw8_rdata", r.rdata, 32'h0);
    check("sw8_busy_cnt", 32'(r.busy_cnt), 32'd3);
    check("sw8_ready_cyc", 32'(r.ready_cyc), 32'd4);
    run_req("lw8", 1'b0, SZ_W, 1'b0, 32'h8, 32'h0, 1'b0, r);
    check("lw8_rsp_cyc", 32'(r.rsp_cyc), 32'd3);
    check("lw8_rdata", r.rdata, 32'h12345678);
    check("lw8_err", 32'(r.err), 32'd0);
    check("lw8_swe", 32'(r.swe), 32'd0);
    check("lw8_bwe", 32'(r.bwe), 32'h0);

    // 2: byte store, signed/unsigned byte loads (word 2 becomes 0x12348078)
    run_req("sb9", 1'b1, SZ_B, 1'b0, 32'h9, 32'h00000080, 1'b0, r);
    check("sb9_bwe", 32'(r.bwe), 32'h2);
    check("sb9_wdata", r.wdata, 32'h80808080);
    run_req("lb9", 1'b0, SZ_B, 1'b0, 32'h9, 32'h0, 1'b0, r);
    check("lb9_rdata", r.rdata, 32'hFFFFFF80);
    run_req("lbu9", 1'b0, SZ_B, 1'b1, 32'h9, 32'h0, 1'b0, r);
    check("lbu9_rdata", r.rdata, 32'h00000080);

    // 3: half store/loads (word 2 becomes 0x80018078), misaligned half
    run_req("shA", 1'b1, SZ_H, 1'b0, 32'hA, 32'h00008001, 1'b0, r);
    check("shA_bwe", 32'(r.bwe), 32'hC);
    check("shA_wdata", r.wdata, 32'h80018001);
    run_req("lhA", 1'b0, SZ_H, 1'b0, 32'hA, 32'h0, 1'b0, r);
    check("lhA_rdata", r.rdata, 32'hFFFF8001);
    run_req("lhuA", 1'b0, SZ_H, 1'b1, 32'hA, 32'h0, 1'b0, r);
    check("lhuA_rdata", r.rdata, 32'h00008001);
    @(negedge clk);
    check("rdata_hold", o_rdata, 32'h00008001);
    run_req("lh9", 1'b0, SZ_H, 1'b0, 32'h9, 32'h0, 1'b0, r);
    check("lh9_err", 32'(r.err), 32'd1);
    check("lh9_rsp_cyc", 32'(r.rsp_cyc), 32'd1);
    check("lh9_cs_cnt", 32'(r.cs_cnt), 32'd0);
    check("lh9_rdata", r.rdata, 32'h0);
    check("lh9_ready_cyc", 32'(r.ready_cyc), 32'd2);

    // 4: range / size / word alignment errors
    run_req("lw_oob", 1'b0, SZ_W, 1'b0, 32'h1000, 32'h0, 1'b0, r);
    check("lw_oob_err", 32'(r.err), 32'd1);
    check("lw_oob_rdata", r.rdata, 32'h0);
    check("lw_oob_cs_cnt", 32'(r.cs_cnt), 32'd0);
    run_req("sz11", 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 1'b0, r);
    check("sz11_err", 32'(r.err), 32'd1);
    run_req("lwA", 1'b0, SZ_W, 1'b0, 32'hA, 32'h0, 1'b0, r);
    check("lwA_err", 32'(r.err), 32'd1);
    run_req("lw_last", 1'b0, SZ_W, 1'b0, 32'hFFC, 32'h0, 1'b0, r);
    check("lw_last_err", 32'(r.err), 32'd0);
    check("lw_last_rsp_cyc", 32'(r.rsp_cyc), 32'd3);

    // 5: WAIT_STATES=4 instance, held request accepted as soon as ready returns
    sel = 1'b1;
    run_req("ws4_sw", 1'b1, SZ_W, 1'b0, 32'hC, 32'hCAFEF00D, 1'b0, r);
    check("ws4_sw_rsp_cyc", 32'(r.rsp_cyc), 32'd6);
    run_req("ws4_lw", 1'b0, SZ_W, 1'b0, 32'hC, 32'h0, 1'b1, r);
    check("ws4_lw_cs_cyc", 32'(r.cs_cyc), 32'd1);
    check("ws4_lw_rsp_cyc", 32'(r.rsp_cyc), 32'd6);
    check("ws4_lw_rdata", r.rdata, 32'hCAFEF00D);
    check("ws4_lw_busy_cnt", 32'(r.busy_cnt), 32'd6);
    check("ws4_lw_ready_cyc", 32'(r.ready_cyc), 32'd7);
    @(negedge clk);
    check("ws4_hold_issue", 32'(o_cs), 32'd1);
    req_valid = 1'b0;
    wait_n = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (o_rsp_valid) begin
        wait_n = i;
        break;
      end
    end
    check("ws4_hold_rsp_delay", 32'(wait_n), 32'd5);
    check("ws4_hold_rdata", o_rdata, 32'hCAFEF00D);
    @(negedge clk);
    sel = 1'b0;

    // 6: reset during WAIT of a load drops the response
    req_we = 1'b0; req_size = SZ_W; req_uns = 1'b0; req_addr = 32'h8; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rst6_issue_cs", 32'(o_cs), 32'd1);
    @(negedge clk);
    check("rst6_wait_busy", 32'(o_busy), 32'd1);
    rst1 = 1'b1;
    @(negedge clk);
    check("rst6_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("rst6_busy", 32'(o_busy), 32'd0);
    check("rst6_cs", 32'(o_cs), 32'd0);
    check("rst6_ready", 32'(o_ready), 32'd0);
    check("rst6_rdata", o_rdata, 32'h0);
    rst1 = 1'b0;
    #1;
    check("rst6_ready_release", 32'(o_ready), 32'd1);
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (o_rsp_valid) pulses++;
    end
    check("rst6_no_rsp", 32'(pulses), 32'd0);

    check("rsp_ready_exclusive", 32'(excl_viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_lsu_ctrl.md
Name: dmem_lsu_ctrl

Overview:
- Parametrised load/store controller between the CPU datapath and a synchronous single-port data SRAM.
- Successor to the fixed single-cycle Data_Memory path.
- Adds a valid/ready request handshake, configurable SRAM read latency (wait states), and byte/half/word stores with per-byte write enables.
- Adds sign/zero-extended sub-word loads, plus misalignment and out-of-range error responses.
- The CPU stalls while busy is high.

Parameters:
ADDR_W, 32, request address width
DEPTH_WORDS, 1024, SRAM depth in 32-bit words
WAIT_STATES, 1, SRAM read latency in cycles after the cs cycle; legal range 1..15, anything else is an elaboration error

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept (high only in IDLE)
req_we  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  zero-extend sub-word loads (lbu/lhu)
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  formatted load data; 0 for stores and errors
rsp_err  out  1  misaligned, illegal size, or out of range; qualified by rsp_valid
busy  out  1  request in flight (state != IDLE)
sram_cs  out  1  SRAM select
sram_we  out  1  SRAM write
sram_bwe  out  4  byte write enables
sram_addr  out  $clog2(DEPTH_WORDS)  word address
sram_wdata  out  32  lane-replicated write data
sram_rdata  in  32  read data, valid WAIT_STATES cycles after the cs cycle

Behaviour:
- Reset values: req_ready=0 during rst, then 1 in IDLE. All other outputs (rsp_*, busy, sram_*) are 0. State=IDLE, wait counter=0.
- Accept: req_valid && req_ready at a rising edge. Request fields are registered. Requests while busy are ignored; no buffering.
- Error check at accept:
  - half with addr[0]!=0 is an error.
  - word with addr[1:0]!=0 is an error.
  - size=11 is an error.
  - addr[ADDR_W-1:2] >= DEPTH_WORDS is an error.
- FSM states:
  - IDLE: on accept, go to RESP if error, else ISSUE.
  - ISSUE: one cycle. sram_cs=1, sram_we=req_we, sram_addr=word index, sram_bwe/wdata per lane rules. Go to WAIT with counter=WAIT_STATES.
  - WAIT: counter decrements each cycle. In the cycle counter==1: for loads, sram_rdata is captured, formatted into rsp_rdata, and the FSM goes to RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then IDLE. req_ready returns the following cycle.
- Latency: accept edge at cycle 0.
  - Normal access: rsp_valid in cycle WAIT_STATES+2 (3 for default).
  - Error: rsp_valid in cycle 1, with rsp_err=1, rsp_rdata=0, and no SRAM activity.
- Store lanes:
  - byte: bwe = 1<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - half: bwe = addr[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}.
  - word: bwe = 1111.
- Load format:
  - byte: select lane addr[1:0].
  - half: select lane addr[1].
  - Sub-word results are sign-extended unless req_unsigned; req_unsigned is ignored for word.
  - sram_bwe=0 and sram_we=0 on loads.
- rsp_rdata holds its value until the next RESP. It is cleared to 0 for store and error responses.
- Back-to-back requests: max throughput is one request per WAIT_STATES+3 cycles. A request held through RESP is accepted in the next IDLE cycle.
- Reset mid-operation: the next cycle is IDLE with all outputs at reset values. The in-flight response is dropped. A store whose ISSUE cycle already occurred stays written.
- rsp_valid and req_ready are never high in the same cycle.

Decomposition:
- Package dmem_pkg:
  - size encodings SZ_B/SZ_H/SZ_W.
  - state enum IDLE/ISSUE/WAIT/RESP.
  - bwe constants.
- Sub-module dmem_lane_fmt (combinational): generates bwe and replicated wdata from size/addr[1:0], and extracts/extends load data. Used by both paths.
- Top holds the FSM, wait counter, request registers and error check.

Test Plan:
1. sw addr 0x8, wdata 0x12345678, then lw 0x8 -> store bwe=1111, sram_addr=2; load rsp_rdata=0x12345678, rsp_valid at cycle 3 after accept, rsp_err=0.
2. sb 0x80 to addr 0x9, then lb 0x9 and lbu 0x9 -> bwe=0010, wdata=0x80808080; lb=0xFFFFFF80, lbu=0x00000080.
3. sh 0x8001 to addr 0xA, then lh 0xA and lhu 0xA -> bwe=1100; lh=0xFFFF8001, lhu=0x00008001; lh 0x9 -> rsp_err=1 at cycle 1, sram_cs never high.
4. lw addr 4*DEPTH_WORDS (0x1000) -> rsp_err=1, rsp_rdata=0; req_size=11 -> rsp_err=1.
5. WAIT_STATES=4 build, lw -> sram_cs in cycle 1, capture in cycle 5, rsp_valid in cycle 6; req_valid held high is accepted in cycle 7; busy high cycles 1-6.
6. rst asserted in the WAIT cycle of a load -> next cycle all outputs 0, no rsp_valid, req_ready=1 after rst is released.
